pacman_mover: RTL and testbench
===============================

PACMAN_MOVER -- requirements
Module: pacman_mover

Interface
Parameters:
REQ-001 GRID_W, 28, maze width in tiles; legal x = 0..GRID_W-1.
REQ-002 GRID_H, 31, maze height in tiles; legal y = 0..GRID_H-1.
REQ-003 TICKS_PER_STEP, 4, clock cycles spent in IDLE between movement steps; minimum 1.
REQ-004 START_X, 13, x position at reset.
REQ-005 START_Y, 23, y position at reset.
Ports:
REQ-006 clock  in  1  the single clock; all state changes on its rising edge.
REQ-007 resetn  in  1  reset, asynchronous and active-low.
REQ-008 dir_in  in  16  direction code; [15:8] x byte, [7:0] y byte.
REQ-009 dir_valid  in  1  dir_in is sampled this cycle.
REQ-010 wall_req  out  1  wall lookup request.
REQ-011 wall_x, wall_y  out  5 each  target tile of the lookup.
REQ-012 wall_ack  in  1  lookup complete; wall_hit is valid this cycle.
REQ-013 wall_hit  in  1  1 = target tile is a wall.
REQ-014 pos_x, pos_y  out  5 each  current tile.
REQ-015 cur_dir  out  16  committed direction code.
REQ-016 moving  out  1  last step moved.
REQ-017 step_pulse  out  1  one-cycle pulse on each position update.

Function
REQ-018 The block SHALL decode exactly four legal codes: 0x0100 LEFT (x-1), 0xFF00 RIGHT (x+1), 0x0001 DOWN (y+1), 0x00FF UP (y-1).
REQ-019 A dir_valid cycle with a legal code SHALL overwrite the pending register; the last write wins.
REQ-020 A dir_valid cycle with any other code, including 0x0000 and diagonals such as 0xFFFF, SHALL be ignored.
REQ-021 The FSM states SHALL be IDLE, PICK, QUERY and DECIDE.
REQ-022 IDLE: the tick counter increments each cycle; at count TICKS_PER_STEP-1 the counter clears and the FSM goes to PICK.
REQ-023 The tick counter SHALL be held at 0 outside IDLE.
REQ-024 PICK, candidate choice: candidate = pending when pending is nonzero and differs from cur_dir; otherwise candidate = cur_dir.
REQ-025 PICK, zero candidate: if the candidate is 0, moving<=0 and the FSM returns to IDLE.
REQ-026 x target SHALL wrap (tunnel): x=0 moving LEFT targets GRID_W-1; x=GRID_W-1 moving RIGHT targets 0.
REQ-027 y target SHALL NOT wrap: y=0 moving UP, or y=GRID_H-1 moving DOWN, is treated as blocked with no lookup issued.
REQ-028 QUERY: wall_req=1 with wall_x/wall_y stable until wall_ack=1; wall_hit is sampled in the wall_ack cycle; wall_req=0 in the following cycle.
REQ-029 Back-to-back lookups SHALL have at least one cycle of wall_req=0 between them.
REQ-030 wall_ack while wall_req=0 SHALL be ignored.
REQ-031 DECIDE, not blocked: pos<=target, cur_dir<=candidate, pending cleared if candidate came from pending, step_pulse=1 for one cycle, moving<=1, FSM to IDLE.
REQ-032 DECIDE, pending candidate blocked: pending is retained and a second evaluation (boundary check or lookup) SHALL be made with cur_dir within the same step.
REQ-033 DECIDE, cur_dir blocked or zero: position unchanged, moving<=0, FSM to IDLE.
REQ-034 dir_valid in the same cycle as PICK: PICK uses the old pending value; the new code is stored for the next step.
REQ-035 At most one position update SHALL occur per step; minimum step period is TICKS_PER_STEP+3 cycles.

Reset
REQ-036 resetn=0 SHALL immediately force: pos=(START_X,START_Y), cur_dir=0, pending=0, wall_req=0, wall_x=0, wall_y=0, moving=0, step_pulse=0, tick counter=0, FSM=IDLE.
REQ-037 Reset during QUERY SHALL abort the lookup; a wall_ack arriving after reset is ignored.

Verification
REQ-038 Reset, then 0x0100 on dir_valid, wall_hit=0 -> lookup at (12,23); pos=(12,23), cur_dir=0x0100, one step_pulse.
REQ-039 pos=(0,14), cur_dir=0x0100, wall_hit=0 -> wall_x=27; pos=(27,14).
REQ-040 cur_dir=0x0100, pending=0x00FF, UP lookup wall_hit=1 then LEFT lookup wall_hit=0 -> two requests in the step; pos x-1; pending stays 0x00FF.
REQ-041 dir_in=0xFFFF or 0x0000 with dir_valid -> pending unchanged; pos=(0,0) with DOWN... pos y=0 with cur_dir UP -> no wall_req, moving=0.
REQ-042 wall_ack delayed 5 cycles -> wall_req and wall_x/wall_y held stable; resetn pulsed mid-wait -> wall_req=0 at once, pos=(13,23).

Source files
------------

// File: rtl/pacman_mover.sv
// Tile-stepping mover: buffers a requested direction, checks the target tile
// through a wall-lookup handshake once per step, and commits the move if clear.
module pacman_mover #(
  parameter int GRID_W         = 28,
  parameter int GRID_H         = 31,
  parameter int TICKS_PER_STEP = 4,
  parameter int START_X        = 13,
  parameter int START_Y        = 23
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] dir_in,
  input  logic        dir_valid,
  output logic        wall_req,
  output logic [4:0]  wall_x,
  output logic [4:0]  wall_y,
  input  logic        wall_ack,
  input  logic        wall_hit,
  output logic [4:0]  pos_x,
  output logic [4:0]  pos_y,
  output logic [15:0] cur_dir,
  output logic        moving,
  output logic        step_pulse
);

  localparam logic [15:0] DIR_LEFT  = 16'h0100;
  localparam logic [15:0] DIR_RIGHT = 16'hFF00;
  localparam logic [15:0] DIR_DOWN  = 16'h0001;
  localparam logic [15:0] DIR_UP    = 16'h00FF;

  localparam int            TW        = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [4:0]    X_MAX     = 5'(GRID_W - 1);
  localparam logic [4:0]    Y_MAX     = 5'(GRID_H - 1);
  localparam logic [4:0]    X_START   = 5'(START_X);
  localparam logic [4:0]    Y_START   = 5'(START_Y);

  typedef enum logic [1:0] {IDLE, PICK, QUERY, DECIDE} state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tick;
  logic [15:0]   pending;
  logic [15:0]   cand;
  logic          cand_pend;
  logic          blocked;

  logic          dir_legal;
  logic [15:0]   pick_cand;
  logic          pick_from_pend;
  logic [10:0]   pick_tgt;
  logic [10:0]   retry_tgt;
  logic          do_move;
  logic          do_retry;

  // Result is {blocked, target_x, target_y}; x tunnels, y stops at the edges.
  function automatic logic [10:0] step_target(input logic [15:0] dir,
                                              input logic [4:0]  x,
                                              input logic [4:0]  y);
    logic       blk;
    logic [4:0] tx;
    logic [4:0] ty;
    blk = 1'b0;
    tx  = x;
    ty  = y;
    case (dir)
      DIR_LEFT:  tx = (x == 5'd0) ? X_MAX : x - 5'd1;
      DIR_RIGHT: tx = (x == X_MAX) ? 5'd0 : x + 5'd1;
      DIR_DOWN: begin
        if (y == Y_MAX) blk = 1'b1;
        else            ty  = y + 5'd1;
      end
      DIR_UP: begin
        if (y == 5'd0) blk = 1'b1;
        else           ty  = y - 5'd1;
      end
      default: blk = 1'b1;
    endcase
    return {blk, tx, ty};
  endfunction

  assign dir_legal = (dir_in == DIR_LEFT) || (dir_in == DIR_RIGHT) ||
                     (dir_in == DIR_DOWN) || (dir_in == DIR_UP);

  assign pick_from_pend = (pending != 16'h0) && (pending != cur_dir);
  assign pick_cand      = pick_from_pend ? pending : cur_dir;
  assign pick_tgt       = step_target(pick_cand, pos_x, pos_y);
  assign retry_tgt      = step_target(cur_dir, pos_x, pos_y);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tick == TICK_LAST) state_next = PICK;
      end
      PICK: begin
        if (pick_cand == 16'h0)  state_next = IDLE;
        else if (pick_tgt[10])   state_next = DECIDE;
        else                     state_next = QUERY;
      end
      QUERY: begin
        if (wall_ack) state_next = DECIDE;
      end
      DECIDE: begin
        if (do_retry && !retry_tgt[10]) state_next = QUERY;
        else                            state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A blocked pending candidate falls back to the committed direction once.
  always_comb begin
    wall_req = (state == QUERY);
    do_move  = (state == DECIDE) && !blocked;
    do_retry = (state == DECIDE) && blocked && cand_pend && (cur_dir != 16'h0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick       <= '0;
      pending    <= 16'h0;
      cand       <= 16'h0;
      cand_pend  <= 1'b0;
      blocked    <= 1'b0;
      wall_x     <= 5'd0;
      wall_y     <= 5'd0;
      pos_x      <= X_START;
      pos_y      <= Y_START;
      cur_dir    <= 16'h0;
      moving     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;

      if (state == IDLE && tick != TICK_LAST) tick <= tick + TW'(1);
      else                                    tick <= '0;

      // A fresh legal code outranks the clear that accompanies its consumption.
      if (dir_valid && dir_legal)  pending <= dir_in;
      else if (do_move && cand_pend) pending <= 16'h0;

      case (state)
        PICK: begin
          cand      <= pick_cand;
          cand_pend <= pick_from_pend;
          if (pick_cand == 16'h0) begin
            moving <= 1'b0;
          end else if (pick_tgt[10]) begin
            blocked <= 1'b1;
          end else begin
            wall_x <= pick_tgt[9:5];
            wall_y <= pick_tgt[4:0];
          end
        end
        QUERY: begin
          if (wall_ack) blocked <= wall_hit;
        end
        DECIDE: begin
          if (do_move) begin
            pos_x      <= wall_x;
            pos_y      <= wall_y;
            cur_dir    <= cand;
            moving     <= 1'b1;
            step_pulse <= 1'b1;
          end else if (do_retry && !retry_tgt[10]) begin
            cand      <= cur_dir;
            cand_pend <= 1'b0;
            wall_x    <= retry_tgt[9:5];
            wall_y    <= retry_tgt[4:0];
          end else begin
            moving <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover: a step-level procedural model of the mover plus a
// maze-backed wall responder, compared against the DUT on every cycle.
module tb_pacman_mover;
  localparam int GW  = 28;
  localparam int GH  = 31;
  localparam int TPS = 4;
  localparam int SX  = 13;
  localparam int SY  = 23;

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] dir_in;
  logic        dir_valid;
  logic        wall_req;
  logic [4:0]  wall_x;
  logic [4:0]  wall_y;
  logic        wall_ack;
  logic        wall_hit;
  logic [4:0]  pos_x;
  logic [4:0]  pos_y;
  logic [15:0] cur_dir;
  logic        moving;
  logic        step_pulse;

  always #5 clock = ~clock;

  pacman_mover #(
    .GRID_W(GW), .GRID_H(GH), .TICKS_PER_STEP(TPS), .START_X(SX), .START_Y(SY)
  ) dut (
    .clock(clock), .resetn(resetn), .dir_in(dir_in), .dir_valid(dir_valid),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir),
    .moving(moving), .step_pulse(step_pulse)
  );

  int errors = 0;
  int checks = 0;

  bit maze [GW][GH];

  // Model state and per-cycle expectations
  int          m_x, m_y, m_moves;
  logic [15:0] m_cur, m_pend;
  bit          m_moving;
  bit          exp_req, exp_pulse;
  int          exp_wx, exp_wy;
  bit          clr_pend;
  bit          drv_dv;
  logic [15:0] drv_din;
  bit          ack_now, hit_now, rand_en, spur_en;
  int          fixed_delay;
  logic [15:0] dir_q[$];
  int          n_lookups, lk_x, lk_y, pulses_total, step_no;
  bit          f_blk;
  int          f_tx, f_ty;
  logic [15:0] code_tab [8];

  function automatic bit legal(input logic [15:0] c);
    return c == 16'h0100 || c == 16'hFF00 || c == 16'h0001 || c == 16'h00FF;
  endfunction

  task automatic target(input logic [15:0] d, input int x, input int y,
                        output bit blk, output int tx, output int ty);
    blk = 1'b0; tx = x; ty = y;
    case (d)
      16'h0100: tx = (x + GW - 1) % GW;
      16'hFF00: tx = (x + 1) % GW;
      16'h0001: if (y + 1 >= GH) blk = 1'b1; else ty = y + 1;
      16'h00FF: if (y - 1 < 0)   blk = 1'b1; else ty = y - 1;
      default:  blk = 1'b1;
    endcase
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_cycle();
    bit ok;
    ok = (pos_x == 5'(m_x)) && (pos_y == 5'(m_y)) && (cur_dir == m_cur) &&
         (moving == m_moving) && (step_pulse == exp_pulse) && (wall_req == exp_req);
    if (exp_req) ok = ok && (wall_x == 5'(exp_wx)) && (wall_y == 5'(exp_wy));
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cycle_state t=%0t got pos=(%0d,%0d) dir=%04h mov=%0b pulse=%0b req=%0b w=(%0d,%0d) want pos=(%0d,%0d) dir=%04h mov=%0b pulse=%0b req=%0b w=(%0d,%0d)",
               $time, pos_x, pos_y, cur_dir, moving, step_pulse, wall_req, wall_x, wall_y,
               m_x, m_y, m_cur, m_moving, exp_pulse, exp_req, exp_wx, exp_wy);
    end
    if (step_pulse) pulses_total++;
  endtask

  // One DUT cycle: settle the pending register, check outputs, drive inputs.
  task automatic cyc();
    @(negedge clock);
    if (drv_dv && legal(drv_din)) m_pend = drv_din;
    else if (clr_pend)            m_pend = 16'h0;
    clr_pend = 1'b0;
    check_cycle();
    drv_dv  = 1'b0;
    drv_din = 16'h0;
    if (dir_q.size() > 0) begin
      drv_dv  = 1'b1;
      drv_din = dir_q.pop_front();
    end else if (rand_en && $urandom_range(0, 7) == 0) begin
      drv_dv  = 1'b1;
      drv_din = code_tab[$urandom_range(0, 7)];
      if (drv_din == 16'h1234) drv_din = 16'($urandom);
    end
    dir_valid = drv_dv;
    dir_in    = drv_dv ? drv_din : 16'($urandom);
    if (ack_now) begin
      wall_ack = 1'b1; wall_hit = hit_now;
    end else if (spur_en && !exp_req && $urandom_range(0, 3) == 0) begin
      wall_ack = 1'b1; wall_hit = 1'($urandom);
    end else begin
      wall_ack = 1'b0; wall_hit = 1'($urandom);
    end
  endtask

  task automatic lookup(input int tx, input int ty, output bit hit);
    int d;
    d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
    exp_req = 1'b1; exp_wx = tx; exp_wy = ty;
    n_lookups++; lk_x = tx; lk_y = ty;
    hit = maze[tx][ty];
    for (int i = 0; i <= d; i++) begin
      ack_now = (i == d);
      hit_now = hit;
      cyc();
    end
    ack_now = 1'b0;
    exp_req = 1'b0;
  endtask

  task automatic do_step();
    logic [15:0] c;
    bit          from_p, blk, hit;
    int          tx, ty;
    n_lookups = 0;
    cyc();
    exp_pulse = 1'b0;
    repeat (TPS - 1) cyc();
    cyc();  // decision point: m_pend now holds what the mover sees
    from_p = (m_pend != 16'h0) && (m_pend != m_cur);
    c      = from_p ? m_pend : m_cur;
    if (c == 16'h0) begin
      m_moving = 1'b0;
    end else begin
      target(c, m_x, m_y, blk, tx, ty);
      if (blk) begin
        hit = 1'b1;
        cyc();
      end else begin
        lookup(tx, ty, hit);
        cyc();
      end
      if (hit && from_p && m_cur != 16'h0) begin
        c      = m_cur;
        from_p = 1'b0;
        target(c, m_x, m_y, blk, tx, ty);
        if (blk) hit = 1'b1;
        else begin
          lookup(tx, ty, hit);
          cyc();
        end
      end
      if (!hit) begin
        m_x = tx; m_y = ty; m_cur = c; m_moving = 1'b1;
        exp_pulse = 1'b1; m_moves++;
        if (from_p) clr_pend = 1'b1;
      end else begin
        m_moving = 1'b0;
      end
    end
    step_no++;
    $display("step %0d pos=(%0d,%0d) dir=%04h lookups=%0d moving=%0b",
             step_no, m_x, m_y, m_cur, n_lookups, m_moving);
  endtask

  task automatic model_reset();
    m_x = SX; m_y = SY; m_cur = 16'h0; m_pend = 16'h0; m_moving = 1'b0;
    exp_req = 1'b0; exp_pulse = 1'b0; exp_wx = 0; exp_wy = 0;
    clr_pend = 1'b0; drv_dv = 1'b0; drv_din = 16'h0; ack_now = 1'b0;
    dir_q.delete();
  endtask

  task automatic reset_pins(input string tag);
    lit({tag, "_pos_x"}, int'(pos_x), 13);
    lit({tag, "_pos_y"}, int'(pos_y), 23);
    lit({tag, "_cur_dir"}, int'(cur_dir), 0);
    lit({tag, "_moving"}, int'(moving), 0);
    lit({tag, "_wall_req"}, int'(wall_req), 0);
    lit({tag, "_wall_x"}, int'(wall_x), 0);
    lit({tag, "_wall_y"}, int'(wall_y), 0);
    lit({tag, "_step_pulse"}, int'(step_pulse), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    code_tab[0] = 16'h0100; code_tab[1] = 16'hFF00; code_tab[2] = 16'h0001;
    code_tab[3] = 16'h00FF; code_tab[4] = 16'h0000; code_tab[5] = 16'hFFFF;
    code_tab[6] = 16'h0101; code_tab[7] = 16'h1234;
    resetn = 1'b0; dir_valid = 1'b0; dir_in = 16'h0; wall_ack = 1'b0; wall_hit = 1'b0;
    rand_en = 1'b0; spur_en = 1'b0; fixed_delay = 0;
    m_moves = 0; pulses_total = 0; step_no = 0;
    model_reset();
    for (int x = 0; x < GW; x++) for (int y = 0; y < GH; y++) maze[x][y] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_pins("reset");
    resetn = 1'b1;

    // First move left from the start tile
    dir_q.push_back(16'h0100);
    do_step();
    lit("left_lookup_x", lk_x, 12);
    lit("left_lookup_y", lk_y, 23);
    lit("left_pos_x", m_x, 12);
    lit("left_dir", int'(m_cur), 16'h0100);
    lit("left_lookups", n_lookups, 1);

    // Walk to x=0, then tunnel to the right edge
    repeat (12) do_step();
    lit("edge_pos_x", m_x, 0);
    do_step();
    lit("tunnel_lookup_x", lk_x, 27);
    lit("tunnel_pos_x", m_x, 27);

    // Pending UP hits a wall, fallback LEFT succeeds, UP remains pending
    maze[27][22] = 1'b1;
    dir_q.push_back(16'h00FF);
    do_step();
    lit("fallback_lookups", n_lookups, 2);
    lit("fallback_pos_x", m_x, 26);
    lit("fallback_pending", int'(m_pend), 16'h00FF);
    do_step();
    lit("pending_up_pos_y", m_y, 22);
    lit("pending_up_dir", int'(m_cur), 16'h00FF);

    // Illegal codes are ignored
    dir_q.push_back(16'hFFFF);
    dir_q.push_back(16'h0000);
    do_step();
    lit("illegal_dir", int'(m_cur), 16'h00FF);
    lit("illegal_pending", int'(m_pend), 0);
    lit("illegal_pos_y", m_y, 21);
    repeat (21) do_step();
    lit("top_pos_y", m_y, 0);
    do_step();
    lit("top_lookups", n_lookups, 0);
    lit("top_moving", int'(m_moving), 0);

    // Pending RIGHT walled while UP is off the top edge: no move, pending kept
    maze[27][0] = 1'b1;
    dir_q.push_back(16'hFF00);
    do_step();
    lit("edge_retry_lookups", n_lookups, 1);
    lit("edge_retry_moving", int'(m_moving), 0);
    lit("edge_retry_pending", int'(m_pend), 16'hFF00);
    maze[27][0] = 1'b0;
    do_step();
    lit("edge_retry_pos_x", m_x, 27);

    // Randomized phase
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++) maze[x][y] = ($urandom_range(0, 3) == 0);
    rand_en = 1'b1; spur_en = 1'b1; fixed_delay = -1;
    repeat (150) do_step();

    // Slow lookup, then reset while the request is outstanding
    rand_en = 1'b0; spur_en = 1'b0; fixed_delay = 0;
    for (int x = 0; x < GW; x++) for (int y = 0; y < GH; y++) maze[x][y] = 1'b0;
    dir_q.push_back(16'h0100);
    do_step();
    cyc();
    exp_pulse = 1'b0;
    repeat (TPS - 1) cyc();
    cyc();
    target(m_cur, m_x, m_y, f_blk, f_tx, f_ty);
    exp_req = 1'b1; exp_wx = f_tx; exp_wy = f_ty;
    repeat (5) cyc();
    resetn = 1'b0;
    #1;
    reset_pins("abort");
    model_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    wall_ack = 1'b1;
    wall_hit = 1'b0;
    repeat (3) do_step();
    lit("post_reset_pos_x", m_x, 13);
    dir_q.push_back(16'hFF00);
    do_step();
    lit("post_reset_right_x", m_x, 14);
    do_step();
    lit("pulse_count", pulses_total, m_moves - int'(exp_pulse));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
